shadow_wr_seq: RTL and testbench

Host-side sequencer that commits one software write into a shadowed register by running the complete two-phase update protocol: a phase-clearing read, a first write, a confirming second write, and a check of the target's phase and error flags. It sits between a simple host request port and the `we/re/wd` port of a shadowed register slice. It retries update mismatches, times out a target that does not respond, and latches storage errors as fatal.

---
 rtl/shadow_wr_seq.sv | 169 ++++++++++++++++
 tb/tb_shadow_wr_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_wr_seq.sv
// Two-phase commit sequencer for a shadowed register: clear, write, confirm, check.
// Define SHADOW_WR_SEQ_READBACK_EN to add a final readback compare of reg_q_i.
module shadow_wr_seq #(
    parameter int DW            = 32,
    parameter int MaxRetry      = 2,
    parameter int TimeoutCycles = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [DW-1:0] req_data_i,
    output logic          done_o,
    output logic [1:0]    status_o,
    output logic          fatal_o,
    output logic          reg_re_o,
    output logic          reg_we_o,
    output logic [DW-1:0] reg_wd_o,
    input  logic          reg_phase_i,
    input  logic          reg_err_update_i,
    input  logic          reg_err_storage_i,
    input  logic [DW-1:0] reg_q_i
);

    localparam int RW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
    localparam int TW = $clog2(TimeoutCycles + 1);

    localparam logic [1:0] STAT_OK      = 2'd0;
    localparam logic [1:0] STAT_UPDATE  = 2'd1;
    localparam logic [1:0] STAT_TIMEOUT = 2'd2;
    localparam logic [1:0] STAT_FATAL   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_WR1,
        S_CHK1,
        S_WR2,
        S_CHK2,
`ifdef SHADOW_WR_SEQ_READBACK_EN
        S_RDBK,
`endif
        S_DONE,
        S_FATAL
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      w_doneStatus;
    logic [DW-1:0]   r_data;
    logic [RW-1:0]   r_retry;
    logic [TW-1:0]   r_tmo;
    logic [1:0]      r_status;
    logic            r_fatal;
    logic            w_tmoExpired;

`ifndef SHADOW_WR_SEQ_READBACK_EN
    logic w_unusedQ;
    assign w_unusedQ = ^reg_q_i;
`endif

    assign w_tmoExpired = (r_tmo == TW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A storage error overrides every other transition; the sticky flag steers DONE into FATAL.
    always_comb begin
        w_next       = r_state;
        w_doneStatus = r_status;
        case (r_state)
            S_IDLE:  if (req_valid_i) w_next = S_CLEAR;
            S_CLEAR: w_next = S_WR1;
            S_WR1:   w_next = S_CHK1;
            S_CHK1: begin
                if (reg_phase_i) begin
                    w_next = S_WR2;
                end else if (w_tmoExpired) begin
                    w_next       = S_DONE;
                    w_doneStatus = STAT_TIMEOUT;
                end
            end
            S_WR2: begin
                if (reg_err_update_i) begin
                    if (r_retry < RW'(MaxRetry)) begin
                        w_next = S_CLEAR;
                    end else begin
                        w_next       = S_DONE;
                        w_doneStatus = STAT_UPDATE;
                    end
                end else begin
                    w_next = S_CHK2;
                end
            end
            S_CHK2: begin
                if (!reg_phase_i) begin
`ifdef SHADOW_WR_SEQ_READBACK_EN
                    w_next = S_RDBK;
`else
                    w_next       = S_DONE;
                    w_doneStatus = STAT_OK;
`endif
                end else if (w_tmoExpired) begin
                    w_next       = S_DONE;
                    w_doneStatus = STAT_TIMEOUT;
                end
            end
`ifdef SHADOW_WR_SEQ_READBACK_EN
            S_RDBK: begin
                w_next       = S_DONE;
                w_doneStatus = (reg_q_i == r_data) ? STAT_OK : STAT_UPDATE;
            end
`endif
            S_DONE:  w_next = r_fatal ? S_FATAL : S_IDLE;
            S_FATAL: w_next = S_FATAL;
            default: w_next = S_IDLE;
        endcase
        if (reg_err_storage_i && (r_state != S_FATAL)) begin
            if (r_fatal) begin
                w_next = S_FATAL;
            end else begin
                w_next       = S_DONE;
                w_doneStatus = STAT_FATAL;
            end
        end
    end

    always_comb begin
        req_ready_o = (r_state == S_IDLE);
        reg_re_o    = (r_state == S_CLEAR);
        reg_we_o    = (r_state == S_WR1) || (r_state == S_WR2);
        done_o      = (r_state == S_DONE);
        status_o    = r_status;
        fatal_o     = r_fatal;
        reg_wd_o    = r_data;
    end

    // Both counters saturate; the retry count is only bumped below MaxRetry, so it cannot wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data   <= '0;
            r_retry  <= '0;
            r_tmo    <= '0;
            r_status <= STAT_OK;
            r_fatal  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && (w_next == S_CLEAR)) begin
                r_data  <= req_data_i;
                r_retry <= '0;
            end else if ((r_state == S_WR2) && (w_next == S_CLEAR)) begin
                r_retry <= r_retry + RW'(1);
            end
            if ((r_state == S_WR1) || (r_state == S_WR2)) begin
                r_tmo <= '0;
            end else if (((r_state == S_CHK1) && !reg_phase_i) ||
                         ((r_state == S_CHK2) && reg_phase_i)) begin
                if (r_tmo < TW'(TimeoutCycles)) r_tmo <= r_tmo + TW'(1);
            end
            if (w_next == S_DONE) r_status <= w_doneStatus;
            if (reg_err_storage_i && (r_state != S_FATAL)) r_fatal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shadow_wr_seq.sv
// Scoreboard bench for shadow_wr_seq against a behavioural shadowed-register target.
// Expected status, latency and pulse counts come from a per-attempt timing formula.
module tb_shadow_wr_seq;

    localparam int DW = 32;
    localparam int MR = 2;
    localparam int TC = 16;
`ifdef SHADOW_WR_SEQ_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef enum int {M_NORMAL, M_ONCE, M_STUCK, M_QBAD} mode_t;

    typedef struct {
        logic [1:0]    status;
        int            lat;
        int            re;
        int            we;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [DW-1:0] reqData = '0;
    logic          done;
    logic [1:0]    status;
    logic          fatal;
    logic          regRe;
    logic          regWe;
    logic [DW-1:0] regWd;
    logic          phaseOut;
    logic          errUpd;
    logic          stor = 1'b0;
    logic [DW-1:0] qOut;

    mode_t         mode = M_NORMAL;
    int            delay = 0;
    logic          phaseReg;
    logic          onceUsed;
    int            sinceWe;
    logic [DW-1:0] qReg;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   acceptCycle = 0;
    int   reCnt = 0;
    int   weCnt = 0;
    int   wdBad = 0;
    int   overlap = 0;

    shadow_wr_seq #(.DW(DW), .MaxRetry(MR), .TimeoutCycles(TC)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (reqValid),
        .req_ready_o       (reqReady),
        .req_data_i        (reqData),
        .done_o            (done),
        .status_o          (status),
        .fatal_o           (fatal),
        .reg_re_o          (regRe),
        .reg_we_o          (regWe),
        .reg_wd_o          (regWd),
        .reg_phase_i       (phaseOut),
        .reg_err_update_i  (errUpd),
        .reg_err_storage_i (stor),
        .reg_q_i           (qOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Target: re clears phase, we toggles it, second write commits; phase visibility can lag.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phaseReg <= 1'b0;
            sinceWe  <= 0;
            qReg     <= '0;
            onceUsed <= 1'b0;
        end else begin
            if (regRe) begin
                phaseReg <= 1'b0;
            end else if (regWe) begin
                phaseReg <= ~phaseReg;
                if (phaseReg && !errUpd) qReg <= regWd;
            end
            if (regWe) sinceWe <= 0;
            else if (sinceWe < 1000) sinceWe <= sinceWe + 1;
            if (reqValid && reqReady) onceUsed <= 1'b0;
            else if (regWe && errUpd) onceUsed <= 1'b1;
        end
    end

    assign errUpd   = (mode == M_STUCK) || ((mode == M_ONCE) && !onceUsed && phaseReg);
    assign phaseOut = phaseReg && (sinceWe >= delay);
    assign qOut     = (mode == M_QBAD) ? '0 : qReg;

    // Each attempt reaches its confirming write 4+d cycles after the previous one began.
    function automatic exp_t model(input mode_t m, input int d, input logic [DW-1:0] data);
        exp_t e;
        int   attempts;
        e.data = data;
        if (d >= TC) begin
            e.status = 2'd2;
            e.lat    = 3 + TC;
            e.re     = 1;
            e.we     = 1;
            return e;
        end
        attempts = (m == M_ONCE) ? 2 : (m == M_STUCK) ? MR + 1 : 1;
        e.re = attempts;
        e.we = 2 * attempts;
        if (m == M_STUCK) begin
            e.status = 2'd1;
            e.lat    = attempts * (4 + d) + 1;
        end else begin
            e.status = ((m == M_QBAD) && (RB == 1)) ? 2'd1 : 2'd0;
            e.lat    = attempts * (4 + d) + 2 + RB;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: tracks bus pulses since acceptance and scores each done_o against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (reqValid && reqReady) begin
                acceptCycle = cycle;
                reCnt = 0;
                weCnt = 0;
                wdBad = 0;
                overlap = 0;
            end
            if (regRe) reCnt++;
            if (regWe) weCnt++;
            if (regRe && regWe) overlap++;
            if (regWe && (sb.size() > 0) && (regWd !== sb[0].data)) wdBad++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done at cycle %0d", cycle);
                end else begin
                    e = sb.pop_front();
                    checkOutput("status", 64'(status), 64'(e.status));
                    checkOutput("latency", 64'(cycle - acceptCycle), 64'(e.lat));
                    checkOutput("re_pulses", 64'(reCnt), 64'(e.re));
                    checkOutput("we_pulses", 64'(weCnt), 64'(e.we));
                    checkOutput("wd_mismatch", 64'(wdBad), 64'd0);
                    checkOutput("re_we_overlap", 64'(overlap), 64'd0);
                    checkOutput("ready_in_done", 64'(reqReady), 64'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input mode_t m, input int d, input logic [DW-1:0] data, input bit storFault);
        exp_t e;
        bit   acc;
        int   n;
        mode  = m;
        delay = d;
        e = model(m, d, data);
        if (storFault) begin
            e.status = 2'd3;
            e.lat    = 4;
            e.re     = 1;
            e.we     = 1;
        end
        sb.push_back(e);
        reqData  = data;
        reqValid = 1'b1;
        n = 0;
        do begin
            acc = reqReady;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        reqValid = 1'b0;
        reqData  = $urandom;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got ready 0, expected 1");
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done_o, expected one within 300 cycles");
            sb.delete();
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_ready", 64'(reqReady), 64'd1);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_status", 64'(status), 64'd0);
        checkOutput("rst_fatal", 64'(fatal), 64'd0);
        checkOutput("rst_re", 64'(regRe), 64'd0);
        checkOutput("rst_we", 64'(regWe), 64'd0);
        checkOutput("rst_wd", 64'(regWd), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] data;
        int            bad;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues();
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(M_NORMAL, 0, 32'hA5A5_0001, 1'b0);
        waitDone();
        applyStimulus(M_ONCE, 0, 32'h0BAD_F00D, 1'b0);
        waitDone();
        applyStimulus(M_STUCK, 0, 32'h1357_9BDF, 1'b0);
        waitDone();
        applyStimulus(M_NORMAL, TC - 1, 32'h0000_FFFF, 1'b0);
        waitDone();
        applyStimulus(M_NORMAL, TC, 32'hFFFF_0000, 1'b0);
        waitDone();
        applyStimulus(M_NORMAL, 1000, 32'h2468_ACE0, 1'b0);
        waitDone();
        applyStimulus(M_QBAD, 0, 32'h0000_1234, 1'b0);
        waitDone();

        for (int i = 0; i < 25; i++) begin
            data = $urandom;
            if (data == '0) data = 32'h1;
            applyStimulus(mode_t'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2)),
                          data, 1'b0);
            waitDone();
        end

        // Storage error during CHK1, then check the absorbing FATAL state.
        applyStimulus(M_NORMAL, 0, 32'hDEAD_BEEF, 1'b1);
        bad = 0;
        while (!regWe && bad < 20) begin
            @(posedge clk);
            #1;
            bad++;
        end
        @(posedge clk);
        #1;
        stor = 1'b1;
        @(posedge clk);
        #1;
        stor = 1'b0;
        waitDone();
        @(posedge clk);
        #1;
        checkOutput("fatal_sticky", 64'(fatal), 64'd1);
        checkOutput("fatal_status", 64'(status), 64'd3);
        reqValid = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (reqReady || regRe || regWe || done) bad++;
            @(posedge clk);
            #1;
        end
        reqValid = 1'b0;
        checkOutput("fatal_quiet", 64'(bad), 64'd0);
        rst = 1'b1;
        #1;
        checkResetValues();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(M_NORMAL, 0, 32'h7777_0001, 1'b0);
        waitDone();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
